// File: rtl/vote_ballot_collector_pkg.sv
// Shared types and constants for the ballot collector that feeds the 3-input
// majority voter.
package vote_ballot_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_CLOSED = 2'd2
  } state_e;

  localparam int NUM_VOTERS = 3;
  localparam int V_A = 0;
  localparam int V_B = 1;
  localparam int V_C = 2;

  // A timeout of 0 still needs a 1-bit timer, since the timer is never zero-width.
  function automatic int timer_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/vote_ballot_collector_timeout_timer.sv
// Down-counter that bounds how long a ballot stays open; saturates at zero
// and flags the final allowed cycle.
module vote_timeout_timer
  import vote_ballot_collector_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int TW = timer_w(TIMEOUT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = TW'(TIMEOUT_CYCLES);
    end else if (dec_i && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Expiry marks the last permitted OPEN cycle, so strobes in it still count.
  assign expire_o = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(1));

endmodule

// File: rtl/vote_ballot_collector.sv
// Opens a ballot on start, latches one vote per voter, and closes on
// completion or timeout, presenting A/B/C with a one-cycle ballot_valid.
module vote_ballot_collector
  import vote_ballot_collector_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = 1000,
  parameter logic DEFAULT_VOTE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_VOTERS-1:0] vote_valid,
  input  logic [NUM_VOTERS-1:0] vote_val,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  ballot_valid,
  output logic                  timed_out,
  output logic [NUM_VOTERS-1:0] voted,
  output logic                  busy,
  output logic                  dup_err
);

  state_e                  state_q, state_d;
  logic [NUM_VOTERS-1:0]   votes_q, votes_d;
  logic [NUM_VOTERS-1:0]   voted_q, voted_d;
  logic [NUM_VOTERS-1:0]   accept;
  logic                    timed_out_q, timed_out_d;
  logic                    dup_q, dup_d;
  logic                    tmr_load, tmr_dec, tmr_expire;

  vote_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (tmr_load),
    .dec_i   (tmr_dec),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    votes_d     = votes_q;
    voted_d     = voted_q;
    timed_out_d = timed_out_q;
    dup_d       = 1'b0;
    accept      = '0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_OPEN;
          voted_d     = '0;
          timed_out_d = 1'b0;
          tmr_load    = 1'b1;
        end
      end
      ST_OPEN: begin
        tmr_dec = 1'b1;
        accept  = vote_valid & ~voted_q;
        dup_d   = |(vote_valid & voted_q);
        votes_d = (votes_q & ~accept) | (vote_val & accept);
        voted_d = voted_q | accept;
        // Completion is checked first so a last-cycle full ballot is not a timeout.
        if (&voted_d) begin
          state_d = ST_CLOSED;
        end else if (tmr_expire) begin
          state_d     = ST_CLOSED;
          timed_out_d = 1'b1;
          votes_d     = (votes_d & voted_d) | ({NUM_VOTERS{DEFAULT_VOTE}} & ~voted_d);
        end
      end
      ST_CLOSED: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      votes_q     <= '0;
      voted_q     <= '0;
      timed_out_q <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      votes_q     <= votes_d;
      voted_q     <= voted_d;
      timed_out_q <= timed_out_d;
      dup_q       <= dup_d;
    end
  end

  assign A            = votes_q[V_A];
  assign B            = votes_q[V_B];
  assign C            = votes_q[V_C];
  assign voted        = voted_q;
  assign timed_out    = timed_out_q;
  assign dup_err      = dup_q;
  assign ballot_valid = (state_q == ST_CLOSED);
  assign busy         = (state_q == ST_OPEN) || (state_q == ST_CLOSED);

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed checks of the ballot collector: a TIMEOUT_CYCLES=8 instance for
// most scenarios and a TIMEOUT_CYCLES=4 instance for last-cycle completion.
module tb_vote_ballot_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start_b;
  logic [2:0] vv, vval, vv_b, vval_b;

  logic       a8, b8, c8, bv8, to8, busy8, dup8;
  logic [2:0] voted8;
  logic       a4, b4, c4, bv4, to4, busy4, dup4;
  logic [2:0] voted4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vote_ballot_collector #(.TIMEOUT_CYCLES(8), .DEFAULT_VOTE(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vv), .vote_val(vval),
    .A(a8), .B(b8), .C(c8), .ballot_valid(bv8), .timed_out(to8),
    .voted(voted8), .busy(busy8), .dup_err(dup8)
  );

  vote_ballot_collector #(.TIMEOUT_CYCLES(4), .DEFAULT_VOTE(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vote_valid(vv_b), .vote_val(vval_b),
    .A(a4), .B(b4), .C(c4), .ballot_valid(bv4), .timed_out(to4),
    .voted(voted4), .busy(busy4), .dup_err(dup4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; vv = 3'b000; vval = 3'b000;
    start_b = 1'b0; vv_b = 3'b000; vval_b = 3'b000;
    tick(); tick();
    chk("rst_abc",   {5'b0, a8, b8, c8}, 8'h00);
    chk("rst_voted", {5'b0, voted8}, 8'h00);
    chk("rst_ctrl",  {4'b0, bv8, to8, busy8, dup8}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Test 1: all three strobes together, earliest close.
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_open_busy", {6'b0, busy8, bv8}, 8'b10);
    vv = 3'b111; vval = 3'b101; tick(); vv = 3'b000;
    chk("t1_bv",    {7'b0, bv8}, 8'h01);
    chk("t1_abc",   {5'b0, a8, b8, c8}, 8'b101);
    chk("t1_voted", {5'b0, voted8}, 8'b111);
    chk("t1_to",    {7'b0, to8}, 8'h00);
    // vote.Result = majority(A,B,C)
    chk("t1_major", {7'b0, (a8 & b8) | (a8 & c8) | (b8 & c8)}, 8'h01);
    tick();
    chk("t1_idle", {5'b0, bv8, busy8, a8}, 8'b001);

    // Test 2: staggered A(c1), C(c3), B(c6).
    start = 1'b1; tick(); start = 1'b0;
    vv = 3'b001; vval = 3'b001; tick();
    vv = 3'b000; tick();
    vv = 3'b100; vval = 3'b000; tick();
    vv = 3'b000; tick(); tick();
    chk("t2_pre_bv", {6'b0, bv8, busy8}, 8'b01);
    vv = 3'b010; vval = 3'b010; tick(); vv = 3'b000;
    chk("t2_bv",  {7'b0, bv8}, 8'h01);
    chk("t2_abc", {5'b0, a8, b8, c8}, 8'b110);
    tick();
    chk("t2_busy_low", {6'b0, busy8, bv8}, 8'b00);

    // Test 3: timeout after exactly 8 OPEN cycles, only A votes.
    start = 1'b1; tick(); start = 1'b0;
    vv = 3'b001; vval = 3'b001; tick(); vv = 3'b000;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_cycle7_open", {6'b0, busy8, bv8}, 8'b10);
    tick();
    chk("t3_bv",    {7'b0, bv8}, 8'h01);
    chk("t3_to",    {7'b0, to8}, 8'h01);
    chk("t3_abc",   {5'b0, a8, b8, c8}, 8'b100);
    chk("t3_voted", {5'b0, voted8}, 8'b001);
    tick();
    chk("t3_hold", {5'b0, to8, bv8, busy8}, 8'b100);

    // Test 4: duplicate strobe and start mid-OPEN.
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_to_clr", {7'b0, to8}, 8'h00);
    vv = 3'b001; vval = 3'b001; tick();
    vv = 3'b001; vval = 3'b000; tick();
    chk("t4_dup",   {6'b0, dup8, a8}, 8'b11);
    vv = 3'b000; start = 1'b1; tick(); start = 1'b0;
    chk("t4_dup_once", {7'b0, dup8}, 8'h00);
    chk("t4_start_ign", {4'b0, busy8, voted8}, 8'b1001);
    vv = 3'b110; vval = 3'b000; tick(); vv = 3'b000;
    chk("t4_close", {4'b0, bv8, a8, b8, c8}, 8'b1100);
    chk("t4_to",    {7'b0, to8}, 8'h00);
    tick();

    // Test 6: reset mid-OPEN with voted=011.
    start = 1'b1; tick(); start = 1'b0;
    vv = 3'b011; vval = 3'b011; tick(); vv = 3'b000;
    chk("t6_voted", {5'b0, voted8}, 8'b011);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_state", {5'b0, busy8, bv8, to8}, 8'h00);
    chk("t6_abc",   {5'b0, a8, b8, c8}, 8'h00);
    chk("t6_voted0", {5'b0, voted8}, 8'h00);
    vv = 3'b111; vval = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle_ign", {4'b0, bv8, dup8, busy8, a8}, 8'h00);
    end
    vv = 3'b000;

    // Test 5: T=4, B and C in the 4th (final) OPEN cycle complete normally.
    start_b = 1'b1; tick(); start_b = 1'b0;
    vv_b = 3'b001; vval_b = 3'b001; tick();
    vv_b = 3'b000; tick(); tick();
    vv_b = 3'b110; vval_b = 3'b110; tick(); vv_b = 3'b000;
    chk("t5_bv",    {6'b0, bv4, to4}, 8'b10);
    chk("t5_abc",   {5'b0, a4, b4, c4}, 8'b111);
    chk("t5_voted", {5'b0, voted4}, 8'b111);
    tick();
    // Same instance, only A votes: forced close after 4 OPEN cycles.
    start_b = 1'b1; tick(); start_b = 1'b0;
    vv_b = 3'b001; vval_b = 3'b000; tick(); vv_b = 3'b000;
    tick(); tick();
    chk("t5b_pre", {6'b0, bv4, busy4}, 8'b01);
    tick();
    chk("t5b_to",  {6'b0, bv4, to4}, 8'b11);
    chk("t5b_abc", {2'b0, a4, b4, c4, voted4}, 8'b000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
